// File: rtl/gps_ch_wb_regs.sv
// gps_ch_wb_regs: Wishbone register bank for one GPS tracking channel (NCO/config words, E/P/L snapshots, STATUS).
// Optional interrupt output irq_o and STATUS.IEN (bit 8) are enabled by defining GPS_CH_IRQ_EN.
module gps_ch_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h00000A00,
    parameter int          ACC_W     = 24
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    output logic [31:0]      code_freq_o,
    output logic [31:0]      carr_freq_o,
    output logic [31:0]      code_off_o,
    output logic [31:0]      carr_off_o,
    output logic [31:0]      acq_thr_o,
    output logic [31:0]      confg_o,
    output logic             cfg_wr_o,
`ifdef GPS_CH_IRQ_EN
    output logic             irq_o,
`endif
    input  logic             dump_i,
    input  logic [ACC_W-1:0] ip_i,
    input  logic [ACC_W-1:0] qp_i,
    input  logic [ACC_W-1:0] il_i,
    input  logic [ACC_W-1:0] ql_i,
    input  logic [ACC_W-1:0] ie_i,
    input  logic [ACC_W-1:0] qe_i
);
    logic [7:0]              off;
    logic [5:0]              idx;
    logic                    sel, ack_d, wr, wr_stat;
    logic                    ready, ovr, ready_c, ovr_c;
    logic [5:0][31:0]        rw;
    logic [5:0][ACC_W-1:0]   snap, acc_in;
    logic [ACC_W-1:0]        snap_sel;
    logic [2:0]              sidx;
    logic [31:0]             status, rdata;
`ifdef GPS_CH_IRQ_EN
    logic                    ien;
    assign status = {23'b0, ien, 6'b0, ovr, ready};
`else
    assign status = {30'b0, ovr, ready};
`endif

    assign off     = wb_adr_i[7:0];
    assign idx     = off[7:2];
    assign sel     = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
    assign ack_d   = sel & ~wb_ack_o;
    assign wr      = ack_d & wb_we_i & (off[1:0] == 2'b00);
    assign wr_stat = wr & (idx == 6'd12);
    // Software clear is applied before a coincident dump is evaluated
    assign ready_c = ready & ~(wr_stat & ~wb_dat_i[0]);
    assign ovr_c   = ovr & ~(wr_stat & ~wb_dat_i[1]);
    assign acc_in  = {qe_i, ie_i, ql_i, il_i, qp_i, ip_i};
    assign sidx    = 3'(idx - 6'd6);
    assign snap_sel = snap[sidx];

    assign code_freq_o = rw[0];
    assign carr_freq_o = rw[1];
    assign code_off_o  = rw[2];
    assign carr_off_o  = rw[3];
    assign acq_thr_o   = rw[4];
    assign confg_o     = rw[5];

    always_comb begin
        rdata = '0;
        rdata = (off[1:0] != 2'b00) ? '0 :
                (idx < 6'd6)  ? rw[idx[2:0]] :
                (idx < 6'd12) ? {{(32-ACC_W){snap_sel[ACC_W-1]}}, snap_sel} :
                (idx == 6'd12) ? status : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            cfg_wr_o <= 1'b0;
            rw       <= '0;
            snap     <= '0;
            ready    <= 1'b0;
            ovr      <= 1'b0;
`ifdef GPS_CH_IRQ_EN
            ien      <= 1'b0;
            irq_o    <= 1'b0;
`endif
        end else begin
            wb_ack_o <= ack_d;
            wb_dat_o <= (ack_d & ~wb_we_i) ? rdata : '0;
            cfg_wr_o <= wr & (idx < 6'd6);
            if (wr && idx < 6'd6)
                rw[idx[2:0]] <= wb_dat_i;
            ready <= ready_c | dump_i;
            ovr   <= ovr_c | (dump_i & ready_c);
            if (dump_i && !ready_c)
                snap <= acc_in;
`ifdef GPS_CH_IRQ_EN
            if (wr_stat)
                ien <= wb_dat_i[8];
            irq_o <= ready & ien;
`endif
        end
    end
endmodule

// File: tb/tb_gps_ch_wb_regs.sv
// tb_gps_ch_wb_regs: table-driven Wishbone vectors plus hand-written dump/STATUS/reset sequences.
module tb_gps_ch_wb_regs;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] adr = '0, dat_i = '0, dat_o;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, cfg_wr, dump = 1'b0;
    logic [31:0] code_freq, carr_freq, code_off, carr_off, acq_thr, confg;
    logic [23:0] ip = '0, qp = '0, il = '0, ql = '0, ie = '0, qe = '0;
`ifdef GPS_CH_IRQ_EN
    logic        irq;
`endif
    int checks = 0, failures = 0, cfg_cnt = 0;

    gps_ch_wb_regs dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .code_freq_o(code_freq), .carr_freq_o(carr_freq), .code_off_o(code_off),
        .carr_off_o(carr_off), .acq_thr_o(acq_thr), .confg_o(confg), .cfg_wr_o(cfg_wr),
`ifdef GPS_CH_IRQ_EN
        .irq_o(irq),
`endif
        .dump_i(dump), .ip_i(ip), .qp_i(qp), .il_i(il), .ql_i(ql), .ie_i(ie), .qe_i(qe)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (cfg_wr) cfg_cnt++;

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic        ack_exp;
        logic        cfg_exp;
        logic [31:0] rd_exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bounded Wishbone transfer; gives up after 8 cycles without ack
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] r, output logic acked, output logic cfgp);
        @(negedge clk);
        adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
        acked = 1'b0; r = '0; cfgp = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin acked = 1'b1; r = dat_o; cfgp = cfg_wr; end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; logic k, c;
        xfer(a, 1'b0, '0, r, k, c);
        check({name, " ack"}, {31'b0, k}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; logic k, c;
        xfer(a, 1'b1, d, r, k, c);
        check({name, " ack"}, {31'b0, k}, 32'd1);
    endtask

    task automatic set_acc(input logic [23:0] vip);
        ip = vip; qp = 24'h800000; il = 24'h7FFFFF; ql = 24'h000001; ie = 24'h0003E8; qe = 24'hFFFFFF;
    endtask

    task automatic pulse_dump;
        @(negedge clk); dump = 1'b1;
        @(negedge clk); dump = 1'b0;
    endtask

    initial begin
        logic [31:0] r; logic k, c; int acks;
        vecs[0]  = '{"w carr",     32'h00000A04, 1'b1, 32'h0FBD5296, 1'b1, 1'b1, 32'h0};
        vecs[1]  = '{"w code",     32'h00000A00, 1'b1, 32'h16EA95A4, 1'b1, 1'b1, 32'h0};
        vecs[2]  = '{"r carr",     32'h00000A04, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0FBD5296};
        vecs[3]  = '{"r code",     32'h00000A00, 1'b0, 32'h0,        1'b1, 1'b0, 32'h16EA95A4};
        vecs[4]  = '{"w confg",    32'h00000A14, 1'b1, 32'h00000123, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{"r confg",    32'h00000A14, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000123};
        vecs[6]  = '{"w ro pi",    32'h00000A18, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{"r pi rst",   32'h00000A18, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[8]  = '{"w unmapped", 32'h00000A34, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{"r unmapped", 32'h00000A34, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[10] = '{"w miss",     32'h00000B04, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{"r miss",     32'h00000B04, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};

        repeat (2) @(negedge clk);
        check("rst ack", {31'b0, ack}, 32'd0);
        check("rst dat", dat_o, 32'd0);
        check("rst cfg_wr", {31'b0, cfg_wr}, 32'd0);
        check("rst carr", carr_freq, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, r, k, c);
            check({vecs[i].name, " ack"}, {31'b0, k}, {31'b0, vecs[i].ack_exp});
            check({vecs[i].name, " cfg"}, {31'b0, c}, {31'b0, vecs[i].cfg_exp});
            if (!vecs[i].we) check({vecs[i].name, " data"}, r, vecs[i].rd_exp);
        end
        check("carr_freq_o", carr_freq, 32'h0FBD5296);
        check("code_freq_o", code_freq, 32'h16EA95A4);
        check("confg_o", confg, 32'h00000123);
        check("cfg_wr count", cfg_cnt, 3);
        rd("status idle", 32'h00000A30, 32'h0);

        // Held strobe: acked every other cycle
        @(negedge clk); adr = 32'h00000A04; we = 1'b0; cyc = 1'b1; stb = 1'b1; acks = 0;
        repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        check("b2b acks", acks, 2);

        set_acc(24'hFFFF38);
        pulse_dump;
        rd("status ready", 32'h00000A30, 32'h1);
        rd("pi neg", 32'h00000A18, 32'hFFFFFF38);
        rd("pq min", 32'h00000A1C, 32'hFF800000);
        rd("li max", 32'h00000A20, 32'h007FFFFF);
        rd("ei", 32'h00000A28, 32'h000003E8);
        rd("eq", 32'h00000A2C, 32'hFFFFFFFF);

        set_acc(24'd5);
        pulse_dump;
        rd("status ovr", 32'h00000A30, 32'h3);
        rd("pi held", 32'h00000A18, 32'hFFFFFF38);
        wr("clr status", 32'h00000A30, 32'h0);
        rd("status clr", 32'h00000A30, 32'h0);

        set_acc(24'd9);
        pulse_dump;
        rd("pi nine", 32'h00000A18, 32'h9);
        // STATUS clear coincident with dump: clear first, then dump latches
        set_acc(24'd7);
        @(negedge clk); adr = 32'h00000A30; we = 1'b1; dat_i = 32'h0; cyc = 1'b1; stb = 1'b1; dump = 1'b1;
        @(posedge clk); #1;
        check("coinc ack", {31'b0, ack}, 32'd1);
        @(negedge clk); dump = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd("status coinc", 32'h00000A30, 32'h1);
        rd("pi coinc", 32'h00000A18, 32'h7);

        // Snapshot read coincident with a latching dump returns the old value
        wr("clr again", 32'h00000A30, 32'h0);
        set_acc(24'h000011);
        @(negedge clk); adr = 32'h00000A18; we = 1'b0; cyc = 1'b1; stb = 1'b1; dump = 1'b1;
        @(posedge clk); #1;
        check("rd-dump ack", {31'b0, ack}, 32'd1);
        check("rd-dump old", dat_o, 32'h7);
        @(negedge clk); dump = 1'b0; cyc = 1'b0; stb = 1'b0;
        rd("pi new", 32'h00000A18, 32'h11);

        // Reset asserted while a write to acq_thr is being acked
        wr("w thr", 32'h00000A10, 32'hAAAA5555);
        check("acq_thr_o", acq_thr, 32'hAAAA5555);
        @(negedge clk); adr = 32'h00000A10; we = 1'b1; dat_i = 32'h12345678; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("thr ack", {31'b0, ack}, 32'd1);
        rst_n = 1'b0; #1;
        check("rst ack drop", {31'b0, ack}, 32'd0);
        check("rst acq_thr", acq_thr, 32'd0);
        repeat (2) @(negedge clk);
        check("rst ack held", {31'b0, ack}, 32'd0);
        check("rst acq_thr held", acq_thr, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rd("status after rst", 32'h00000A30, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
